// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, data-phase state type and byte-lane helper
// used by the SRAM responder and its RAM array.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DP_IDLE = 2'd0,
    DP_WAIT = 2'd1,
    DP_ERR1 = 2'd2
  } dp_state_e;

  // Sizes above a word collapse to a full-word mask; misaligned halves snap to their half.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] m;
    case (size)
      HSIZE_BYTE: m = 4'b0001 << addr;
      HSIZE_HALF: m = addr[1] ? 4'b1100 : 4'b0011;
      default:    m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Byte-enabled synchronous RAM, 2^ADDR_WIDTH x 32, with one write and one read
// port; a read of the word being written on the same edge returns the merged word.
module ahb_sram_array #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_we,
  input  logic [3:0]            i_be,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [31:0]           i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [31:0]           o_rdata
);

  logic [31:0] r_mem [0:(2**ADDR_WIDTH)-1];
  logic [31:0] r_rdata;
  logic [31:0] w_merged;

  always_comb begin
    w_merged = r_mem[i_raddr];
    for (int b = 0; b < 4; b++) begin
      if (i_we && i_be[b] && (i_waddr == i_raddr)) begin
        w_merged[8*b +: 8] = i_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we && i_be[b]) begin
        r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // Output register only moves on a read, so the bus sees the last read word between reads.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= w_merged;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ahb_lite_sram_responder.sv
// AHB-Lite SRAM responder with configurable data-phase wait states.
// Define AHB_SRAM_ERR_EN to return two-cycle ERROR on misaligned or oversized transfers.
module ahb_lite_sram_responder
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 14,
  parameter int WAIT_STATES = 0
) (
  input  logic        i_hclk,
  input  logic        i_hresetn,
  input  logic        i_hsel,
  input  logic [31:0] i_haddr,
  input  logic [1:0]  i_htrans,
  input  logic [2:0]  i_hsize,
  input  logic [2:0]  i_hburst,
  input  logic [3:0]  i_hprot,
  input  logic        i_hwrite,
  input  logic        i_hmastlock,
  input  logic [31:0] i_hwdata,
  input  logic        i_hready,
  output logic        o_hreadyout,
  output logic        o_hresp,
  output logic [31:0] o_hrdata
);

  dp_state_e             r_state;
  dp_state_e             w_state_nxt;
  logic [1:0]            r_cnt;
  logic [1:0]            w_cnt_nxt;
  logic                  r_pend;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_mask;
  logic                  w_accept;
  logic                  w_err;
  logic                  w_take;
  logic                  w_we;
  logic                  w_re;
  logic                  w_unused;

  assign w_unused = ^{i_hburst, i_hprot, i_hmastlock, i_haddr[31:ADDR_WIDTH+2]};

  assign w_accept = i_hsel & i_hready & i_htrans[1] & (r_state == DP_IDLE);

`ifdef AHB_SRAM_ERR_EN
  logic r_err2;

  assign w_err = (i_hsize > HSIZE_WORD)
               | ((i_hsize == HSIZE_HALF) & i_haddr[0])
               | ((i_hsize == HSIZE_WORD) & (i_haddr[1:0] != 2'b00));
`else
  assign w_err = 1'b0;
`endif

  assign w_take = w_accept & ~w_err;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_hreadyout = 1'b1;
    case (r_state)
      DP_IDLE: begin
        if (w_accept) begin
          if (w_err) begin
            w_state_nxt = DP_ERR1;
          end else if (WAIT_STATES > 0) begin
            w_state_nxt = DP_WAIT;
            w_cnt_nxt   = 2'(WAIT_STATES - 1);
          end
        end
      end
      DP_WAIT: begin
        o_hreadyout = 1'b0;
        if (r_cnt == 2'd0) begin
          w_state_nxt = DP_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 2'd1;
        end
      end
      DP_ERR1: begin
        o_hreadyout = 1'b0;
        w_state_nxt = DP_IDLE;
      end
      default: begin
        w_state_nxt = DP_IDLE;
      end
    endcase
  end

  // r_pend marks a good transfer in its data phase; it completes on the next edge seen in DP_IDLE.
  always_ff @(posedge i_hclk or negedge i_hresetn) begin
    if (!i_hresetn) begin
      r_state <= DP_IDLE;
      r_cnt   <= 2'd0;
      r_pend  <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_mask  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_state == DP_IDLE) begin
        r_pend <= w_take;
      end
      if (w_take) begin
        r_write <= i_hwrite;
        r_addr  <= i_haddr[ADDR_WIDTH+1:2];
        r_mask  <= lane_mask(i_hsize, i_haddr[1:0]);
      end
    end
  end

`ifdef AHB_SRAM_ERR_EN
  always_ff @(posedge i_hclk or negedge i_hresetn) begin
    if (!i_hresetn) begin
      r_err2 <= 1'b0;
    end else begin
      r_err2 <= (r_state == DP_ERR1);
    end
  end

  assign o_hresp = ((r_state == DP_ERR1) | r_err2) ? HRESP_ERROR : HRESP_OKAY;
`else
  assign o_hresp = HRESP_OKAY;
`endif

  assign w_we = r_pend & r_write & (r_state == DP_IDLE);
  assign w_re = w_take & ~i_hwrite;

  ahb_sram_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .i_clk   (i_hclk),
    .i_rst_n (i_hresetn),
    .i_we    (w_we),
    .i_be    (r_mask),
    .i_waddr (r_addr),
    .i_wdata (i_hwdata),
    .i_re    (w_re),
    .i_raddr (i_haddr[ADDR_WIDTH+1:2]),
    .o_rdata (o_hrdata)
  );

endmodule

// File: tb/tb_ahb_lite_sram_responder.sv
// Testbench for ahb_lite_sram_responder: a zero-wait and a two-wait instance share one
// pipelined AHB driver and are checked against a word-array memory model.
module tb_ahb_lite_sram_responder;

  localparam int AW  = 14;
  localparam int WS1 = 2;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
  } xfer_t;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = 2'b00;
  logic [2:0]  hsize = 3'b010;
  logic [2:0]  hburst = 3'b000;
  logic [3:0]  hprot = 4'b0011;
  logic        hwrite = 1'b0;
  logic        hmastlock = 1'b0;
  logic [31:0] hwdata = '0;
  logic        dutSel = 1'b0;

  logic        hready;
  logic        ro0, ro1, rs0, rs1;
  logic [31:0] rd0, rd1;
  logic        hsel0, hsel1;
  logic        hrespMux;
  logic [31:0] hrdataMux;

  assign hsel0     = hsel & ~dutSel;
  assign hsel1     = hsel & dutSel;
  assign hready    = dutSel ? ro1 : ro0;
  assign hrespMux  = dutSel ? rs1 : rs0;
  assign hrdataMux = dutSel ? rd1 : rd0;

  always #5 hclk = ~hclk;

  ahb_lite_sram_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut0 (
    .i_hclk(hclk), .i_hresetn(hresetn), .i_hsel(hsel0), .i_haddr(haddr),
    .i_htrans(htrans), .i_hsize(hsize), .i_hburst(hburst), .i_hprot(hprot),
    .i_hwrite(hwrite), .i_hmastlock(hmastlock), .i_hwdata(hwdata), .i_hready(hready),
    .o_hreadyout(ro0), .o_hresp(rs0), .o_hrdata(rd0)
  );

  ahb_lite_sram_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(WS1)) dut1 (
    .i_hclk(hclk), .i_hresetn(hresetn), .i_hsel(hsel1), .i_haddr(haddr),
    .i_htrans(htrans), .i_hsize(hsize), .i_hburst(hburst), .i_hprot(hprot),
    .i_hwrite(hwrite), .i_hmastlock(hmastlock), .i_hwdata(hwdata), .i_hready(hready),
    .o_hreadyout(ro1), .o_hresp(rs1), .o_hrdata(rd1)
  );

  logic [31:0] mdl [2][16384];
  xfer_t       prev;
  logic        prevAct = 1'b0;
  logic        prevErr = 1'b0;
  int          nChecks = 0;
  int          nFails  = 0;

  function automatic xfer_t mk(input logic sel, input logic [1:0] tr, input logic wr,
                               input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                               input logic chk, input logic [31:0] e);
    xfer_t x;
    x.sel = sel; x.trans = tr; x.wr = wr; x.size = sz;
    x.addr = a; x.wdata = wd; x.chk = chk; x.exp = e;
    return x;
  endfunction

  function automatic logic [3:0] modelLanes(input logic [2:0] size, input logic [31:0] addr);
    int a;
    a = int'(addr % 4);
    if (size == 3'd0) return 4'(1 << a);
    if (size == 3'd1) return (a >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic isErr(input logic [2:0] size, input logic [31:0] addr);
`ifdef AHB_SRAM_ERR_EN
    return (size > 3'd2) || (size == 3'd1 && addr[0]) || (size == 3'd2 && addr[1:0] != 2'b00);
`else
    return 1'b0 && (^{size, addr});
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h (dut%0d, t=%0t)", name, act, exp, dutSel, $time);
    end
  endtask

  // Retire the transfer whose data phase completes at the coming edge.
  task automatic finishPrev(input int waits);
    int          idx;
    int          d;
    logic [3:0]  lanes;
    d = int'(dutSel);
    checkOutput("waitCount", 32'(waits), prevErr ? 32'd1 : (dutSel ? 32'(WS1) : 32'd0));
    checkOutput("hresp", 32'(hrespMux), 32'(prevErr));
    if (!prevErr) begin
      idx = int'((prev.addr >> 2) & ((32'd1 << AW) - 32'd1));
      if (prev.wr) begin
        lanes = modelLanes(prev.size, prev.addr);
        for (int b = 0; b < 4; b++) begin
          if (lanes[b]) mdl[d][idx][8*b +: 8] = prev.wdata[8*b +: 8];
        end
      end else begin
        checkOutput("rdata", hrdataMux, mdl[d][idx]);
        if (prev.chk) checkOutput("rdataConst", hrdataMux, prev.exp);
      end
    end
  endtask

  // Drive the address phase of x while the previous transfer runs its data phase.
  task automatic applyStimulus(input xfer_t x);
    int   waits;
    logic gotReady;
    hsel   = x.sel;
    htrans = x.trans;
    hwrite = x.wr;
    hsize  = x.size;
    haddr  = x.addr;
    hwdata = prev.wdata;
    waits  = 0;
    gotReady = 1'b0;
    while (!gotReady && waits <= 20) begin
      @(negedge hclk);
      if (hready) begin
        gotReady = 1'b1;
      end else begin
        waits++;
        if (prevAct) checkOutput("waitHresp", 32'(hrespMux), 32'(prevErr));
      end
    end
    if (!gotReady) checkOutput("readyTimeout", 32'(hready), 32'd1);
    if (prevAct) finishPrev(waits);
    else checkOutput("idleReady", 32'(waits), 32'd0);
    @(posedge hclk);
    #1;
    prev    = x;
    prevAct = x.sel & x.trans[1];
    prevErr = prevAct & isErr(x.size, x.addr);
  endtask

  task automatic flush();
    applyStimulus(mk(1'b0, 2'b00, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0, 32'h0));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    xfer_t vecs[15];
    xfer_t x;

    prev = mk(1'b0, 2'b00, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0, 32'h0);
    for (int d = 0; d < 2; d++) for (int i = 0; i < 16384; i++) mdl[d][i] = '0;

    vecs[0]  = mk(1, 2'b10, 1, 3'd2, 32'h0000_0040, 32'h1122_3344, 0, 32'h0);
    vecs[1]  = mk(1, 2'b10, 1, 3'd0, 32'h0000_0041, 32'hAAAA_AAAA, 0, 32'h0);
    vecs[2]  = mk(1, 2'b10, 1, 3'd1, 32'h0000_0042, 32'hBEEF_BEEF, 0, 32'h0);
    vecs[3]  = mk(1, 2'b10, 0, 3'd2, 32'h0000_0040, 32'h0,         1, 32'hBEEF_AA44);
    vecs[4]  = mk(1, 2'b10, 1, 3'd2, 32'h0000_0080, 32'hCAFE_F00D, 0, 32'h0);
    vecs[5]  = mk(1, 2'b10, 0, 3'd2, 32'h0000_0080, 32'h0,         1, 32'hCAFE_F00D);
    vecs[6]  = mk(1, 2'b00, 1, 3'd2, 32'h0000_0040, 32'h0000_0000, 0, 32'h0);
    vecs[7]  = mk(1, 2'b01, 1, 3'd2, 32'h0000_0040, 32'h5555_5555, 0, 32'h0);
    vecs[8]  = mk(0, 2'b10, 1, 3'd2, 32'h0000_0040, 32'h6666_6666, 0, 32'h0);
    vecs[9]  = mk(0, 2'b11, 1, 3'd0, 32'h0000_0041, 32'h7777_7777, 0, 32'h0);
    vecs[10] = mk(1, 2'b10, 0, 3'd2, 32'h0000_0040, 32'h0,         1, 32'hBEEF_AA44);
    vecs[11] = mk(1, 2'b10, 0, 3'd2, 32'h0000_0102, 32'h0,         1, 32'h0123_4567);
    vecs[12] = mk(1, 2'b10, 1, 3'd1, 32'h0000_0043, 32'h5566_5566, 0, 32'h0);
    vecs[13] = mk(1, 2'b10, 1, 3'd3, 32'h0001_0080, 32'h0BAD_F00D, 0, 32'h0);
    vecs[14] = mk(1, 2'b10, 0, 3'd2, 32'h0000_0080, 32'h0,         0, 32'h0);

    // Outputs while held in reset
    repeat (2) @(negedge hclk);
    checkOutput("resetReady0", 32'(ro0), 32'd1);
    checkOutput("resetResp0",  32'(rs0), 32'd0);
    checkOutput("resetRdata0", rd0, 32'h0);
    checkOutput("resetReady1", 32'(ro1), 32'd1);
    hresetn = 1'b1;
    @(posedge hclk);
    #1;

    for (int d = 0; d < 2; d++) begin
      dutSel = d[0];
      for (int w = 0; w < 128; w++) begin
        applyStimulus(mk(1, 2'b10, 1, 3'd2, 32'(w * 4), $urandom(), 0, 32'h0));
      end
      flush();
    end

    // Reset in the middle of a write data phase discards the write
    dutSel = 1'b0;
    applyStimulus(mk(1, 2'b10, 1, 3'd2, 32'h100, 32'h0123_4567, 0, 32'h0));
    applyStimulus(mk(1, 2'b10, 0, 3'd2, 32'h100, 32'h0, 1, 32'h0123_4567));
    applyStimulus(mk(1, 2'b10, 1, 3'd2, 32'h100, 32'hDEAD_BEEF, 0, 32'h0));
    hsel    = 1'b0;
    htrans  = 2'b00;
    hwdata  = 32'hDEAD_BEEF;
    hresetn = 1'b0;
    prevAct = 1'b0;
    prev    = mk(1'b0, 2'b00, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0, 32'h0);
    repeat (2) @(negedge hclk);
    checkOutput("midRstReady", 32'(ro0), 32'd1);
    checkOutput("midRstResp",  32'(rs0), 32'd0);
    checkOutput("midRstRdata", rd0, 32'h0);
    hresetn = 1'b1;
    @(posedge hclk);
    #1;
    applyStimulus(mk(1, 2'b10, 0, 3'd2, 32'h100, 32'h0, 1, 32'h0123_4567));
    flush();

    for (int i = 0; i < 15; i++) applyStimulus(vecs[i]);
    flush();

    // Two-wait instance: sequential reads, then write followed directly by a read of that word
    dutSel = 1'b1;
    applyStimulus(mk(1, 2'b10, 0, 3'd2, 32'h10, 32'h0, 0, 32'h0));
    applyStimulus(mk(1, 2'b11, 0, 3'd2, 32'h14, 32'h0, 0, 32'h0));
    applyStimulus(mk(1, 2'b10, 1, 3'd2, 32'h18, 32'h1234_5678, 0, 32'h0));
    applyStimulus(mk(1, 2'b10, 0, 3'd2, 32'h18, 32'h0, 1, 32'h1234_5678));
    flush();

    for (int d = 0; d < 2; d++) begin
      dutSel = d[0];
      for (int i = 0; i < 150; i++) begin
        x.sel   = ($urandom_range(0, 7) != 0);
        x.trans = 2'($urandom_range(0, 3));
        x.wr    = $urandom_range(0, 1) == 1;
        x.size  = 3'($urandom_range(0, 3));
        x.addr  = ($urandom() & 32'hFFFF_0000) | 32'($urandom_range(0, 63) * 4) | 32'($urandom_range(0, 3));
        x.wdata = $urandom();
        x.chk   = 1'b0;
        x.exp   = 32'h0;
        applyStimulus(x);
      end
      flush();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
